// File: rtl/pred_update_pkg.sv
// Shared types for the predictor update path: one update entry and the port count.
// No logic, no latency.
// No flow control; types only.
package pred_update_pkg;

  // PC/target width carried by an update entry; the top-level `size` must match.
  localparam int PC_W          = 32;
  localparam int NUM_UPD_PORTS = 3;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
    logic            is_jalr;
    logic            mispredict;
  } pred_update_t;

endpackage

// File: rtl/pred_update_fifo_mw.sv
// Circular buffer of update entries: up to three writes and one read per cycle.
// Latency: a written entry is readable at the head in the following cycle.
// Backpressure: none; the writer must never ask for more slots than are free.
module pred_update_fifo_mw
  import pred_update_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   i_wr_num,
  input  pred_update_t i_wr_dat [NUM_UPD_PORTS],
  input  logic         i_rd_rdy,
  output logic         o_rd_vld,
  output pred_update_t o_rd_dat,
  output logic [CW-1:0] o_count
);

  pred_update_t  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_deq;

  assign o_rd_vld = (r_count != '0);
  assign w_deq    = i_rd_rdy & o_rd_vld;
  assign o_rd_dat = r_mem[r_head];
  assign o_count  = r_count;

  // Write the first i_wr_num entries at tail onward, pop one at head, track occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_UPD_PORTS; k++) begin
        if (k < int'(i_wr_num)) begin
          r_mem[r_tail + PW'(k)] <= i_wr_dat[k];
        end
      end
      r_tail <= r_tail + PW'(i_wr_num);
      if (w_deq) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(i_wr_num) - CW'(w_deq);
    end
  end

endmodule

// File: rtl/predictor_update_scheduler.sv
// Merges up to three predictor update requests per cycle into one in-order update stream.
// Latency: one cycle from request to head of queue when the queue is empty.
// Backpressure: never stalls the FUs; excess requests are dropped and counted, the output waits on upd_ready_i.
module predictor_update_scheduler
  import pred_update_pkg::*;
#(
  parameter  int size   = 32,
  parameter  int DEPTH  = 8,
  parameter  int DROP_W = 16,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  input  logic              req_valid_2,
  input  logic [size-1:0]   req_pc_0,
  input  logic [size-1:0]   req_pc_1,
  input  logic [size-1:0]   req_pc_2,
  input  logic              req_is_jalr_0,
  input  logic              req_is_jalr_1,
  input  logic              req_is_jalr_2,
  input  logic              req_mispredict_0,
  input  logic              req_mispredict_1,
  input  logic              req_mispredict_2,
  input  logic [size-1:0]   req_target_0,
  input  logic [size-1:0]   req_target_1,
  input  logic [size-1:0]   req_target_2,
  output logic              upd_valid_o,
  input  logic              upd_ready_i,
  output logic [size-1:0]   upd_pc_o,
  output logic [size-1:0]   upd_target_o,
  output logic              upd_is_jalr_o,
  output logic              upd_mispredict_o,
  output logic [CW-1:0]     occupancy_o,
  output logic              full_o,
  output logic [DROP_W-1:0] drop_count_o
);

  pred_update_t      w_req [NUM_UPD_PORTS];
  pred_update_t      w_cmp [NUM_UPD_PORTS];
  pred_update_t      w_head;
  logic [1:0]        w_nvalid;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_free;
  logic [1:0]        w_accept;
  logic [1:0]        w_drops;
  logic [DROP_W:0]   w_drop_sum;
  logic [DROP_W-1:0] r_drop_count;

  assign w_req[0] = '{pc: req_pc_0, target: req_target_0, is_jalr: req_is_jalr_0, mispredict: req_mispredict_0};
  assign w_req[1] = '{pc: req_pc_1, target: req_target_1, is_jalr: req_is_jalr_1, mispredict: req_mispredict_1};
  assign w_req[2] = '{pc: req_pc_2, target: req_target_2, is_jalr: req_is_jalr_2, mispredict: req_mispredict_2};

  assign w_nvalid = {1'b0, req_valid_0} + {1'b0, req_valid_1} + {1'b0, req_valid_2};

  // Pack valid requests to the front in port order so slot k holds the k-th valid request.
  always_comb begin
    w_cmp[0] = req_valid_0 ? w_req[0] : (req_valid_1 ? w_req[1] : w_req[2]);
    w_cmp[1] = (req_valid_0 & req_valid_1) ? w_req[1] : w_req[2];
    w_cmp[2] = w_req[2];
  end

  // Free space comes from the registered count only, so a same-cycle pop never frees a slot.
  assign w_free   = CW'(DEPTH) - w_count;
  // When requests exceed free space, free < 3, so its low two bits hold it exactly.
  assign w_accept = (CW'(w_nvalid) > w_free) ? w_free[1:0] : w_nvalid;
  assign w_drops  = w_nvalid - w_accept;

  pred_update_fifo_mw #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_wr_num (w_accept),
    .i_wr_dat (w_cmp),
    .i_rd_rdy (upd_ready_i),
    .o_rd_vld (upd_valid_o),
    .o_rd_dat (w_head),
    .o_count  (w_count)
  );

  assign w_drop_sum = {1'b0, r_drop_count} + {{(DROP_W-1){1'b0}}, w_drops};

  // Saturating count of dropped requests; requests during reset are not drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= '0;
    end else begin
      r_drop_count <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
    end
  end

  assign upd_pc_o         = w_head.pc;
  assign upd_target_o     = w_head.target;
  assign upd_is_jalr_o    = w_head.is_jalr;
  assign upd_mispredict_o = w_head.mispredict;
  assign occupancy_o      = w_count;
  assign full_o           = (w_count == CW'(DEPTH));
  assign drop_count_o     = r_drop_count;

endmodule

// File: tb/tb_predictor_update_scheduler.sv
// Bench for predictor_update_scheduler: directed scenarios plus random traffic against a queue model.
// Latency: outputs are compared 1 time unit after each rising clock edge.
// Backpressure: upd_ready_i is driven directly by the bench.
module tb_predictor_update_scheduler;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        jalr;
    logic        mis;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        rv  [3];
  logic [31:0] rpc [3];
  logic [31:0] rtg [3];
  logic        rj  [3];
  logic        rm  [3];
  logic        upd_ready;

  logic        upd_valid_o;
  logic [31:0] upd_pc_o;
  logic [31:0] upd_target_o;
  logic        upd_is_jalr_o;
  logic        upd_mispredict_o;
  logic [3:0]  occupancy_o;
  logic        full_o;
  logic [15:0] drop_count_o;

  int   checks   = 0;
  int   failures = 0;
  ent_t mq[$];
  int   mdrops   = 0;

  predictor_update_scheduler #(.size(32), .DEPTH(DEPTH), .DROP_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_0      (rv[0]),
    .req_valid_1      (rv[1]),
    .req_valid_2      (rv[2]),
    .req_pc_0         (rpc[0]),
    .req_pc_1         (rpc[1]),
    .req_pc_2         (rpc[2]),
    .req_is_jalr_0    (rj[0]),
    .req_is_jalr_1    (rj[1]),
    .req_is_jalr_2    (rj[2]),
    .req_mispredict_0 (rm[0]),
    .req_mispredict_1 (rm[1]),
    .req_mispredict_2 (rm[2]),
    .req_target_0     (rtg[0]),
    .req_target_1     (rtg[1]),
    .req_target_2     (rtg[2]),
    .upd_valid_o      (upd_valid_o),
    .upd_ready_i      (upd_ready),
    .upd_pc_o         (upd_pc_o),
    .upd_target_o     (upd_target_o),
    .upd_is_jalr_o    (upd_is_jalr_o),
    .upd_mispredict_o (upd_mispredict_o),
    .occupancy_o      (occupancy_o),
    .full_o           (full_o),
    .drop_count_o     (drop_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0; rpc[i] = '0; rtg[i] = '0; rj[i] = 1'b0; rm[i] = 1'b0;
    end
  endtask

  task automatic req(input int p, input logic [31:0] pc, input logic [31:0] tg, input logic j, input logic m);
    rv[p] = 1'b1; rpc[p] = pc; rtg[p] = tg; rj[p] = j; rm[p] = m;
  endtask

  task automatic check_all();
    chk("valid", upd_valid_o, mq.size() != 0);
    chk("occupancy", occupancy_o, mq.size());
    chk("full", full_o, mq.size() == DEPTH);
    chk("drops", drop_count_o, mdrops);
    if (mq.size() != 0) begin
      chk("head_pc", upd_pc_o, mq[0].pc);
      chk("head_target", upd_target_o, mq[0].target);
      chk("head_jalr", upd_is_jalr_o, mq[0].jalr);
      chk("head_mis", upd_mispredict_o, mq[0].mis);
    end
  endtask

  // Advance the reference queue by one cycle from the current inputs, clock the DUT, then compare.
  task automatic tick(input bit do_chk);
    int   sz0;
    int   fr;
    ent_t e;
    if (reset) begin
      mq.delete();
      mdrops = 0;
    end else begin
      sz0 = mq.size();
      fr  = DEPTH - sz0;
      for (int i = 0; i < 3; i++) begin
        if (rv[i]) begin
          if (fr > 0) begin
            e.pc = rpc[i]; e.target = rtg[i]; e.jalr = rj[i]; e.mis = rm[i];
            mq.push_back(e);
            fr--;
          end else if (mdrops < 65535) begin
            mdrops++;
          end
        end
      end
      if (upd_ready && sz0 > 0) void'(mq.pop_front());
    end
    @(posedge clk);
    #1;
    if (do_chk) check_all();
  endtask

  initial begin
    idle();
    upd_ready = 1'b0;
    reset     = 1'b1;
    tick(1);
    chk("rst_pc", upd_pc_o, 32'h0);
    chk("rst_target", upd_target_o, 32'h0);
    reset = 1'b0;

    // Single request on port 1
    req(1, 32'h100, 32'h0, 1'b0, 1'b1);
    tick(1);
    chk("single_vld", upd_valid_o, 1'b1);
    chk("single_pc", upd_pc_o, 32'h100);
    chk("single_occ", occupancy_o, 4'd1);
    idle();
    upd_ready = 1'b1;
    tick(1);

    // Three ports in one cycle drain in port order
    req(0, 32'h10, 32'h1010, 1'b1, 1'b0);
    req(1, 32'h20, 32'h2020, 1'b0, 1'b1);
    req(2, 32'h30, 32'h3030, 1'b1, 1'b1);
    tick(1);
    chk("ord0", upd_pc_o, 32'h10);
    idle();
    tick(1);
    chk("ord1", upd_pc_o, 32'h20);
    tick(1);
    chk("ord2", upd_pc_o, 32'h30);
    tick(1);
    chk("ord_empty", upd_valid_o, 1'b0);

    // Overflow with output stalled
    upd_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 3; p++) req(p, 32'h200 + 32'(16 * (3 * c + p)), 32'(c), 1'b0, 1'b0);
      tick(1);
    end
    chk("ovf_occ", occupancy_o, 4'd8);
    chk("ovf_full", full_o, 1'b1);
    chk("ovf_drops", drop_count_o, 16'd4);
    chk("ovf_head", upd_pc_o, 32'h200);

    // Full queue: dequeue proceeds, both new requests dropped
    idle();
    upd_ready = 1'b1;
    req(0, 32'hAAA0, 32'h0, 1'b0, 1'b0);
    req(1, 32'hBBB0, 32'h0, 1'b0, 1'b0);
    tick(1);
    chk("fullsim_occ", occupancy_o, 4'd7);
    chk("fullsim_drops", drop_count_o, 16'd6);
    idle();
    for (int i = 0; i < 8; i++) tick(1);

    // Wrap-around streaming
    for (int i = 0; i < 20; i++) begin
      idle();
      req(0, 32'(4 * i), 32'(i), i[0], i[1]);
      tick(1);
    end
    idle();
    tick(1);
    tick(1);
    chk("wrap_empty", upd_valid_o, 1'b0);
    chk("wrap_drops", drop_count_o, 16'd6);

    // Reset mid-operation with a request present
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle();
      req(0, 32'h900 + 32'(i), 32'h0, 1'b0, 1'b0);
      tick(1);
    end
    chk("pre_rst_occ", occupancy_o, 4'd5);
    reset = 1'b1;
    idle();
    req(0, 32'hDEAD, 32'h0, 1'b1, 1'b1);
    tick(1);
    reset = 1'b0;
    idle();
    chk("midrst_occ", occupancy_o, 4'd0);
    chk("midrst_vld", upd_valid_o, 1'b0);
    chk("midrst_drops", drop_count_o, 16'd0);
    chk("midrst_pc", upd_pc_o, 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 2) != 0) req(p, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      upd_ready = 1'($urandom_range(0, 3) == 0);
      reset     = 1'($urandom_range(0, 149) == 0);
      tick(1);
      reset = 1'b0;
    end

    // Drop counter saturation
    idle();
    upd_ready = 1'b0;
    reset     = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int n = 0; n < 21850; n++) begin
      for (int p = 0; p < 3; p++) req(p, 32'(n * 3 + p), 32'h0, 1'b0, 1'b0);
      tick(0);
    end
    check_all();
    chk("sat_drops", drop_count_o, 16'hFFFF);
    tick(1);
    chk("sat_hold", drop_count_o, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
